// File: rtl/conv_tap_mac.sv
// conv_tap_mac: takes the KSIZE-tap pixel window from the pixel queue, multiplies
// each tap by a stored signed weight, sums one tap per cycle and hands
// the dot product to the next conv stage over a valid/ready handshake.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous abort back to IDLE (weights are kept)
//   work            allows a new window to be accepted in IDLE
//   hold            freezes acceptance and MAC progress (does not affect OUT)
//   win_data        flattened window, tap i = win_data[i*DATA_W +: DATA_W], unsigned
//   win_valid       window available (queue full)
//   win_take        high in the cycle whose closing edge latches the window
//   w_we/w_addr/w_data  serial weight write port, honoured only in IDLE
//   res_data        signed dot product, stable while res_valid is high
//   res_valid       result valid (state OUT)
//   res_ready       downstream accept
//   busy            high in MAC or OUT
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a window; weight writes allowed
// MAC   | one tap multiplied and accumulated per non-held cycle
// OUT   | result presented until res_ready
module conv_tap_mac #(
    parameter int KSIZE  = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      work,
    input  logic                      hold,
    input  logic [KSIZE*DATA_W-1:0]   win_data,
    input  logic                      win_valid,
    output logic                      win_take,
    input  logic                      w_we,
    input  logic [$clog2(KSIZE)-1:0]  w_addr,
    input  logic [DATA_W-1:0]         w_data,
    output logic [ACC_W-1:0]          res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy
);

    localparam int AW   = $clog2(KSIZE);
    localparam int PW   = 2 * DATA_W + 1;
    localparam logic [AW-1:0] LAST = AW'(KSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic                      take;
    logic signed [ACC_W-1:0]   acc;
    logic [AW-1:0]             idx;
    logic [DATA_W-1:0]         win_q [KSIZE];
    logic signed [DATA_W-1:0]  w_mem [KSIZE];

    logic signed [DATA_W:0]    pix_s;
    logic signed [DATA_W-1:0]  w_s;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      w_ok;

    // Pixel is zero-extended by one bit so the multiply is fully signed.
    assign pix_s    = {1'b0, win_q[idx]};
    assign w_s      = w_mem[idx];
    assign prod     = PW'(pix_s) * PW'(w_s);
    assign prod_ext = ACC_W'(prod);
    assign w_ok     = ({1'b0, w_addr} < (AW+1)'(KSIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (work && win_valid && !hold) begin
                    take      = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (!hold && idx == LAST) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            take      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
            for (int i = 0; i < KSIZE; i++) begin
                win_q[i] <= '0;
                w_mem[i] <= '0;
            end
        end else if (clear) begin
            acc <= '0;
            idx <= '0;
        end else begin
            if (take) begin
                acc <= '0;
                idx <= '0;
                for (int i = 0; i < KSIZE; i++) begin
                    win_q[i] <= win_data[i*DATA_W +: DATA_W];
                end
            end
            if (state == MAC && !hold) begin
                acc <= acc + prod_ext;
                idx <= idx + 1'b1;
            end
            // A write in the accept cycle lands before the first MAC cycle.
            if (state == IDLE && w_we && w_ok) begin
                w_mem[w_addr] <= w_data;
            end
        end
    end

    assign win_take  = take;
    assign res_data  = acc;
    assign res_valid = (state == OUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_tap_mac.sv
// Bench for conv_tap_mac: random and directed windows checked against a
// plain-arithmetic dot-product model of the stored weights.
module tb_conv_tap_mac;

    localparam int KSIZE  = 5;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;

    typedef int arr_t [KSIZE];

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clear = 1'b0;
    logic                     work = 1'b0;
    logic                     hold = 1'b0;
    logic [KSIZE*DATA_W-1:0]  win_data = '0;
    logic                     win_valid = 1'b0;
    logic                     win_take;
    logic                     w_we = 1'b0;
    logic [2:0]               w_addr = '0;
    logic [DATA_W-1:0]        w_data = '0;
    logic [ACC_W-1:0]         res_data;
    logic                     res_valid;
    logic                     res_ready = 1'b1;
    logic                     busy;

    int checks = 0;
    int errors = 0;
    int w_m [KSIZE];

    always #5 clk = ~clk;

    conv_tap_mac #(.KSIZE(KSIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .work(work), .hold(hold),
        .win_data(win_data), .win_valid(win_valid), .win_take(win_take),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy)
    );

    function automatic logic [KSIZE*DATA_W-1:0] pack(input arr_t p);
        logic [KSIZE*DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < KSIZE; i++) r[i*DATA_W +: DATA_W] = 8'(p[i]);
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] ref_dot(input logic [KSIZE*DATA_W-1:0] win);
        int s;
        s = 0;
        for (int i = 0; i < KSIZE; i++) s += int'(win[i*DATA_W +: DATA_W]) * w_m[i];
        return ACC_W'(s);
    endfunction

    function automatic logic [KSIZE*DATA_W-1:0] rand_win();
        arr_t p;
        for (int i = 0; i < KSIZE; i++) p[i] = int'($urandom_range(255));
        return pack(p);
    endfunction

    task automatic set_weights(input arr_t v);
        for (int i = 0; i < KSIZE; i++) begin
            @(negedge clk);
            w_we = 1'b1; w_addr = 3'(i); w_data = 8'(v[i]);
            w_m[i] = v[i];
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic rand_weights();
        arr_t v;
        for (int i = 0; i < KSIZE; i++) v[i] = int'($urandom_range(255)) - 128;
        set_weights(v);
    endtask

    // Drives one window through accept, MAC and OUT. lat counts cycles from
    // the win_take cycle to the first res_valid cycle.
    task automatic run_window(input logic [KSIZE*DATA_W-1:0] win,
                              input int hold_start, input int hold_len,
                              input int ready_lo, input bit out_wr,
                              output int lat, output logic [ACC_W-1:0] res,
                              output int takes, output bit stable,
                              output bit busy_ok, output bit tmo);
        int n;
        tmo = 0; takes = 0; lat = 0; stable = 1; busy_ok = 1; res = '0;
        @(negedge clk);
        win_data = win; win_valid = 1'b1; work = 1'b1; hold = 1'b0;
        res_ready = (ready_lo == 0);
        #1;
        n = 0;
        while (!win_take && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!win_take) begin
            tmo = 1; win_valid = 1'b0; res_ready = 1'b1;
            return;
        end
        takes = 1;
        if (busy !== 1'b0) busy_ok = 0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            lat++; n++;
            hold = (lat >= hold_start && lat < hold_start + hold_len);
            #1;
            if (win_take) takes++;
            if (busy !== 1'b1) busy_ok = 0;
            if (res_valid) break;
        end
        hold = 1'b0;
        if (!res_valid) begin
            tmo = 1; win_valid = 1'b0; res_ready = 1'b1;
            return;
        end
        res = res_data;
        for (int k = 1; k < ready_lo; k++) begin
            @(negedge clk);
            if (out_wr && k == 1) begin
                w_we = 1'b1; w_addr = 3'd0; w_data = 8'd99;
            end else begin
                w_we = 1'b0;
            end
            #1;
            if (win_take) takes++;
            if (busy !== 1'b1) busy_ok = 0;
            if (res_valid !== 1'b1 || res_data !== res) stable = 0;
        end
        if (ready_lo > 0) begin
            @(negedge clk);
            w_we = 1'b0; res_ready = 1'b1;
            #1;
            if (win_take) takes++;
            if (res_valid !== 1'b1 || res_data !== res) stable = 0;
        end
        @(negedge clk);
        win_valid = 1'b0;
        #1;
        if (busy !== 1'b0 || res_valid !== 1'b0) busy_ok = 0;
    endtask

    task automatic test_reset();
        int lat, takes; logic [ACC_W-1:0] res; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        arr_t p;
        #2;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %0b exp 0", res_valid); end
        checks++;
        if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %0d exp 0", res_data); end
        checks++;
        if (win_take !== 1'b0) begin errors++; $display("FAIL reset_win_take got %0b exp 0", win_take); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        for (int i = 0; i < KSIZE; i++) w_m[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        p = '{10, 20, 30, 40, 50};
        win = pack(p);
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL reset_window_timeout got timeout exp result"); end
        checks++;
        if (res !== 20'd0) begin errors++; $display("FAIL reset_window_result got %0d exp 0", $signed(res)); end
        checks++;
        if (lat !== KSIZE + 1) begin errors++; $display("FAIL reset_window_latency got %0d exp %0d", lat, KSIZE + 1); end
        checks++;
        if (takes !== 1) begin errors++; $display("FAIL reset_window_takes got %0d exp 1", takes); end
    endtask

    task automatic test_basic();
        int lat, takes; logic [ACC_W-1:0] res; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        arr_t p, v;
        v = '{1, 2, 3, 4, 5};
        set_weights(v);
        p = '{10, 20, 30, 40, 50};
        win = pack(p);
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== 20'd550) begin errors++; $display("FAIL basic_result got %0d exp 550 (timeout=%0b)", $signed(res), tmo); end
        checks++;
        if (lat !== KSIZE + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, KSIZE + 1); end
        checks++;
        if (!bok) begin errors++; $display("FAIL basic_busy got profile_bad exp busy only in MAC/OUT"); end
        checks++;
        if (takes !== 1) begin errors++; $display("FAIL basic_takes got %0d exp 1", takes); end
    endtask

    task automatic test_extremes();
        int lat, takes; logic [ACC_W-1:0] res; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        arr_t p, v;
        p = '{255, 255, 255, 255, 255};
        win = pack(p);
        v = '{-128, -128, -128, -128, -128};
        set_weights(v);
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== 20'hD8280) begin errors++; $display("FAIL extreme_neg got %0d exp -163200", $signed(res)); end
        v = '{127, 127, 127, 127, 127};
        set_weights(v);
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== 20'd161925) begin errors++; $display("FAIL extreme_pos got %0d exp 161925", $signed(res)); end
    endtask

    task automatic test_random();
        int lat, takes; logic [ACC_W-1:0] res, exp_r; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        for (int t = 0; t < 8; t++) begin
            rand_weights();
            win = rand_win();
            exp_r = ref_dot(win);
            run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
            checks++;
            if (tmo || res !== exp_r) begin errors++; $display("FAIL random_result[%0d] got %0d exp %0d", t, $signed(res), $signed(exp_r)); end
            checks++;
            if (lat !== KSIZE + 1) begin errors++; $display("FAIL random_latency[%0d] got %0d exp %0d", t, lat, KSIZE + 1); end
        end
    endtask

    task automatic test_hold();
        int lat, takes; logic [ACC_W-1:0] res; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        arr_t p, v;
        v = '{1, 2, 3, 4, 5};
        set_weights(v);
        p = '{10, 20, 30, 40, 50};
        win = pack(p);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            win_data = win; win_valid = 1'b1; work = 1'b1; hold = 1'b1;
            #1;
            checks++;
            if (win_take !== 1'b0) begin errors++; $display("FAIL hold_idle_take[%0d] got %0b exp 0", k, win_take); end
        end
        run_window(win, 2, 3, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== 20'd550) begin errors++; $display("FAIL hold_result got %0d exp 550", $signed(res)); end
        checks++;
        if (lat !== KSIZE + 4) begin errors++; $display("FAIL hold_latency got %0d exp %0d", lat, KSIZE + 4); end
    endtask

    task automatic test_backpressure();
        int lat, takes; logic [ACC_W-1:0] res; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        arr_t p;
        p = '{10, 20, 30, 40, 50};
        win = pack(p);
        run_window(win, 99, 0, 4, 1, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== 20'd550) begin errors++; $display("FAIL bp_result got %0d exp 550", $signed(res)); end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_stable got unstable exp stable valid/data"); end
        checks++;
        if (takes !== 1) begin errors++; $display("FAIL bp_takes got %0d exp 1", takes); end
        // The write issued in OUT must not have reached weight 0.
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== ref_dot(win)) begin errors++; $display("FAIL bp_out_write got %0d exp %0d", $signed(res), $signed(ref_dot(win))); end
    endtask

    task automatic test_abort();
        int lat, takes, n; logic [ACC_W-1:0] res, exp_r; bit stable, bok, tmo;
        logic [KSIZE*DATA_W-1:0] win;
        rand_weights();
        @(negedge clk);
        win_data = rand_win(); win_valid = 1'b1; work = 1'b1; hold = 1'b0; res_ready = 1'b1;
        #1;
        n = 0;
        while (!win_take && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (!win_take) begin errors++; $display("FAIL abort_take got 0 exp 1"); end
        @(negedge clk); win_valid = 1'b0;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
            errors++; $display("FAIL abort_clear got busy=%0b valid=%0b data=%0d exp 0/0/0", busy, res_valid, res_data);
        end
        win = rand_win();
        exp_r = ref_dot(win);
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== exp_r) begin errors++; $display("FAIL abort_old_weights got %0d exp %0d", $signed(res), $signed(exp_r)); end

        @(negedge clk);
        win_data = rand_win(); win_valid = 1'b1; work = 1'b1; res_ready = 1'b0;
        n = 0;
        #1;
        while (!res_valid && n < 30) begin
            @(negedge clk);
            if (win_take === 1'b0 && busy === 1'b1) win_valid = 1'b0;
            #1; n++;
        end
        win_valid = 1'b0;
        checks++;
        if (!res_valid) begin errors++; $display("FAIL rst_reach_out got 0 exp res_valid"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0) begin
            errors++; $display("FAIL rst_async got valid=%0b busy=%0b data=%0d exp 0/0/0", res_valid, busy, res_data);
        end
        for (int i = 0; i < KSIZE; i++) w_m[i] = 0;
        @(negedge clk);
        rst_n = 1'b1; res_ready = 1'b1;
        win = rand_win();
        run_window(win, 99, 0, 0, 0, lat, res, takes, stable, bok, tmo);
        checks++;
        if (tmo || res !== ref_dot(win)) begin errors++; $display("FAIL rst_weights got %0d exp %0d", $signed(res), $signed(ref_dot(win))); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_hold();
        test_backpressure();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
